// File: rtl/picomips_pkg.sv
// picoMips shared types: opcodes, sequencer states
// and the per-opcode control bundle decode.
package picomips_pkg;

  localparam int INSTR_W = 12;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LDI   = 4'h1,
    OP_ADDI  = 4'h2,
    OP_LDR   = 4'h3,
    OP_ADDR  = 4'h4,
    OP_MULI  = 4'h5,
    OP_LDSW  = 4'h6,
    OP_ADDSW = 4'h7,
    OP_STR   = 4'h8,
    OP_WAITH = 4'h9,
    OP_WAITL = 4'hA,
    OP_JMP   = 4'hB,
    OP_BZ    = 4'hC,
    OP_HALT  = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } cu_state_t;

  typedef struct packed {
    logic we;
    logic selsw;
    logic selimm;
    logic usemul;
    logic useacc;
    logic regwe;
  } ctrl_t;

  function automatic ctrl_t decode(
    input logic [3:0] op
  );
    ctrl_t c;
    c = '0;
    unique case (op)
      OP_LDI:   c = 6'b101000;
      OP_ADDI:  c = 6'b101010;
      OP_LDR:   c = 6'b100000;
      OP_ADDR:  c = 6'b100010;
      OP_MULI:  c = 6'b101110;
      OP_LDSW:  c = 6'b110000;
      OP_ADDSW: c = 6'b110010;
      OP_STR:   c = 6'b000001;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/control_unit_sync2.sv
// Two-flop synchroniser for the asynchronous
// Ready button, cleared by synchronous reset.
module sync2 (
  input  logic Clock,
  input  logic nReset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/control_unit.sv
// picoMips decoder/sequencer: PC, RUN/STALL/HALT
// control and combinational instruction decode.
module control_unit
  import picomips_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                Clock,
  input  logic                nReset,
  input  logic [INSTR_W-1:0]  Instr,
  input  logic [7:0]          ACC,
  input  logic                Ready,
  output logic [PC_WIDTH-1:0] PC,
  output logic [7:0]          Imm,
  output logic                WE,
  output logic                SelSW,
  output logic                SelImm,
  output logic                UseMul,
  output logic                UseACC,
  output logic [2:0]          RegAddr,
  output logic                RegWE,
  output logic                Halted,
  output logic                Stalled
);

  cu_state_t           state_q;
  cu_state_t           state_d;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target;
  logic [3:0]          op;
  logic                rdy;
  logic                wait_met;
  logic                is_wait;
  logic                en;
  ctrl_t               ctrl;

  sync2 u_sync (
    .Clock  (Clock),
    .nReset (nReset),
    .d      (Ready),
    .q      (rdy)
  );

  assign op     = Instr[11:8];
  assign Imm    = Instr[7:0];
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign target = Instr[PC_WIDTH-1:0];

  assign is_wait  = (op == OP_WAITH)
                 || (op == OP_WAITL);
  assign wait_met = (op == OP_WAITH) ? rdy : !rdy;

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      RUN: begin
        if (op == OP_JMP) begin
          pc_d = target;
        end else if (op == OP_BZ) begin
          pc_d = (ACC == 8'd0) ? target : pc_inc;
        end else if (is_wait) begin
          if (wait_met) pc_d = pc_inc;
          else          state_d = STALL;
        end else if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          pc_d = pc_inc;
        end
      end
      STALL: begin
        if (wait_met) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Mux selects decode freely; only writes are gated.
  always_comb begin
    ctrl    = decode(op);
    en      = nReset && (state_q == RUN);
    WE      = ctrl.we && en;
    RegWE   = ctrl.regwe && en;
    SelSW   = ctrl.selsw;
    SelImm  = ctrl.selimm;
    UseMul  = ctrl.usemul;
    UseACC  = ctrl.useacc;
    RegAddr = Instr[2:0];
    Halted  = (state_q == HALT);
    Stalled = (state_q == STALL);
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode, branches,
// wait handshakes, wrap, and reset from STALL/HALT.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic [7:0]  ACC = 8'd0;
  logic        Ready = 1'b0;
  logic [11:0] rom [256];
  logic [11:0] rom4 [16];

  logic [11:0] Instr;
  logic [7:0]  PC;
  logic [7:0]  Imm;
  logic        WE, SelSW, SelImm, UseMul, UseACC;
  logic [2:0]  RegAddr;
  logic        RegWE, Halted, Stalled;

  logic [11:0] Instr4;
  logic [3:0]  PC4;
  logic [7:0]  Imm4;
  logic        WE4, SelSW4, SelImm4, UseMul4, UseACC4;
  logic [2:0]  RegAddr4;
  logic        RegWE4, Halted4, Stalled4;

  int n_checks = 0;
  int n_fail = 0;

  logic [5:0] ctl;
  assign ctl = {WE, SelSW, SelImm,
                UseMul, UseACC, RegWE};

  assign Instr  = rom[PC];
  assign Instr4 = rom4[PC4];

  always #5 Clock = ~Clock;

  control_unit #(.PC_WIDTH(8)) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Instr   (Instr),
    .ACC     (ACC),
    .Ready   (Ready),
    .PC      (PC),
    .Imm     (Imm),
    .WE      (WE),
    .SelSW   (SelSW),
    .SelImm  (SelImm),
    .UseMul  (UseMul),
    .UseACC  (UseACC),
    .RegAddr (RegAddr),
    .RegWE   (RegWE),
    .Halted  (Halted),
    .Stalled (Stalled)
  );

  control_unit #(.PC_WIDTH(4)) dut4 (
    .Clock   (Clock),
    .nReset  (nReset),
    .Instr   (Instr4),
    .ACC     (ACC),
    .Ready   (Ready),
    .PC      (PC4),
    .Imm     (Imm4),
    .WE      (WE4),
    .SelSW   (SelSW4),
    .SelImm  (SelImm4),
    .UseMul  (UseMul4),
    .UseACC  (UseACC4),
    .RegAddr (RegAddr4),
    .RegWE   (RegWE4),
    .Halted  (Halted4),
    .Stalled (Stalled4)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    for (int i = 0; i < 16; i++) rom4[i] = 12'h000;
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    tick();
    nReset = 1'b1;
  endtask

  initial begin
    clear_rom();
    rom[0] = 12'h105;
    rom[1] = 12'h203;
    rom[2] = 12'h502;
    rom[3] = 12'hF00;
    rom4[0] = 12'hBF3;

    // reset with LDI presented at PC 0
    nReset = 1'b0;
    tick();
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_halted", 32'(Halted), 32'h0);
    check("rst_stalled", 32'(Stalled), 32'h0);
    check("rst_we", 32'(WE), 32'h0);
    nReset = 1'b1;
    #1;
    check("ldi_ctl", 32'(ctl), 32'h28);
    check("ldi_imm", 32'(Imm), 32'h5);
    tick();
    check("addi_pc", 32'(PC), 32'h1);
    check("addi_ctl", 32'(ctl), 32'h2A);
    check("jmp4_pc", 32'(PC4), 32'h3);
    tick();
    check("muli_pc", 32'(PC), 32'h2);
    check("muli_ctl", 32'(ctl), 32'h2E);
    tick();
    check("halt_dec_pc", 32'(PC), 32'h3);
    check("halt_dec_we", 32'(WE), 32'h0);
    check("halt_dec_h", 32'(Halted), 32'h0);
    tick();
    check("halted", 32'(Halted), 32'h1);
    check("halted_pc", 32'(PC), 32'h3);
    tick();
    check("halted_pc2", 32'(PC), 32'h3);

    // branches, STR, wrap, illegal opcode
    clear_rom();
    rom[8'h00] = 12'hC10;
    rom[8'h10] = 12'hC20;
    rom[8'h11] = 12'h803;
    rom[8'h12] = 12'hBFF;
    rom[8'h01] = 12'hD00;
    ACC = 8'd0;
    do_reset();
    tick();
    check("bz_taken", 32'(PC), 32'h10);
    ACC = 8'h01;
    tick();
    check("bz_not", 32'(PC), 32'h11);
    check("str_regwe", 32'(RegWE), 32'h1);
    check("str_we", 32'(WE), 32'h0);
    check("str_addr", 32'(RegAddr), 32'h3);
    tick();
    check("jmp_pc", 32'(PC), 32'h12);
    tick();
    check("jmp_ff", 32'(PC), 32'hFF);
    tick();
    check("wrap_pc", 32'(PC), 32'h00);
    tick();
    check("bz_acc1_pc", 32'(PC), 32'h01);
    check("op_d_ctl", 32'(ctl), 32'h00);
    tick();
    check("op_d_pc", 32'(PC), 32'h02);

    // wait handshakes
    clear_rom();
    rom[0] = 12'hA00;
    rom[1] = 12'h900;
    rom[2] = 12'h107;
    rom[3] = 12'hA00;
    ACC = 8'd0;
    Ready = 1'b0;
    do_reset();
    tick();
    check("waitl_pc", 32'(PC), 32'h1);
    check("waitl_nostall", 32'(Stalled), 32'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("waith_stall", 32'(Stalled), 32'h1);
      check("waith_pc", 32'(PC), 32'h1);
      check("waith_we", 32'({WE, RegWE}), 32'h0);
      tick();
    end
    Ready = 1'b1;
    tick();
    check("rdy_e1_pc", 32'(PC), 32'h1);
    check("rdy_e1_st", 32'(Stalled), 32'h1);
    tick();
    check("rdy_e2_pc", 32'(PC), 32'h1);
    tick();
    check("rdy_e3_pc", 32'(PC), 32'h2);
    check("rdy_e3_st", 32'(Stalled), 32'h0);
    check("ldi7_we", 32'(WE), 32'h1);
    tick();
    tick();
    check("waitl_stall", 32'(Stalled), 32'h1);
    check("waitl_pc3", 32'(PC), 32'h3);

    // reset from STALL
    Ready = 1'b0;
    nReset = 1'b0;
    tick();
    check("rst_stall_pc", 32'(PC), 32'h0);
    check("rst_stall_st", 32'(Stalled), 32'h0);
    nReset = 1'b1;

    // reset from HALT
    clear_rom();
    rom[0] = 12'hF00;
    #1;
    tick();
    check("halt0", 32'(Halted), 32'h1);
    rom[0] = 12'h101;
    #1;
    check("halt_we", 32'(WE), 32'h0);
    nReset = 1'b0;
    tick();
    check("rst_halt_pc", 32'(PC), 32'h0);
    check("rst_halt_h", 32'(Halted), 32'h0);
    check("rst_ldi_we", 32'(WE), 32'h0);
    nReset = 1'b1;
    #1;
    check("post_rst_we", 32'(WE), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction decoder and sequencer for the picoMips core: drives the accumulator ALU's control and operand inputs from the program ROM. Holds the program counter and decodes one 12-bit instruction per cycle into ALU and register-file controls. Resolves zero-branches on the current accumulator value and stalls on a handshake button for switch-driven programs. Sits between the program ROM, which is read combinationally at `PC`, and the ALU/register file.

## Interface
Parameters:
- `PC_WIDTH`, 8, program counter width; legal range 1..8.

Ports:
- `Clock` input 1 — single clock, rising edge.
- `nReset` input 1 — reset, synchronous, active-low.
- `Instr` input 12 — instruction at `PC`; `Op = Instr[11:8]`, `Imm = Instr[7:0]`.
- `ACC` input 8 — ALU accumulator, used by `BZ`.
- `Ready` input 1 — asynchronous handshake button.
- `PC` output PC_WIDTH — program counter.
- `Imm` output 8 — `Instr[7:0]` passed through.
- `WE` output 1 — ACC write enable.
- `SelSW` output 1 — select switches as operand.
- `SelImm` output 1 — select immediate, else register data.
- `UseMul` output 1 — multiply `ACC*Imm`.
- `UseACC` output 1 — add ACC into the result.
- `RegAddr` output 3 — register file address, `Imm[2:0]`.
- `RegWE` output 1 — register file write enable; written data is ACC.
- `Halted` output 1 — state is HALT.
- `Stalled` output 1 — state is STALL.

## Operation
- Opcodes, giving (`WE`, `SelSW`, `SelImm`, `UseMul`, `UseACC`):
  - 0 NOP: all 0.
  - 1 LDI: 1,0,1,0,0.
  - 2 ADDI: 1,0,1,0,1.
  - 3 LDR: 1,0,0,0,0.
  - 4 ADDR: 1,0,0,0,1.
  - 5 MULI: 1,0,1,1,1.
  - 6 LDSW: 1,1,0,0,0.
  - 7 ADDSW: 1,1,0,0,1.
  - 8 STR: `RegWE=1`, others 0.
  - 9 WAITH.
  - A WAITL.
  - B JMP.
  - C BZ.
  - F HALT.
  - D, E: execute as NOP, `PC` advances.
- `RegWE` is 1 only for STR.
- PC update in RUN:
  - JMP: `PC <= Imm[PC_WIDTH-1:0]`.
  - BZ: `PC <= Imm[PC_WIDTH-1:0]` if `ACC == 0`, else `PC+1`.
  - All other opcodes: `PC+1`, wrapping modulo 2^PC_WIDTH.
- `Ready` passes through a 2-flop synchroniser to give `RdySync`.
- State machine:
  - RUN: WAITH with `RdySync=0`, or WAITL with `RdySync=1` → STALL, PC held. Either one with its condition already met → `PC+1`, stay RUN. HALT → HALT, PC held.
  - STALL: the wait instruction is re-presented; all write enables 0. Wait condition met → RUN, `PC+1`.
  - HALT: PC held, all enables 0; left only by reset.
- Write enables `WE` and `RegWE` are forced to 0 while `nReset` is low and in STALL/HALT.
- In STALL/HALT the mux selects (`SelSW`, `SelImm`, `UseMul`, `UseACC`) still decode normally; they are don't-care there.

## Timing
- Decode is combinational: controls are valid the same cycle `Instr` is valid, and ACC/register writes land at the next rising edge.
- BZ tests ACC as written by the preceding instruction; no forwarding hazard exists.
- Reset, sampled at the clock edge with `nReset=0`:
  - `PC=0`, state RUN, synchroniser flops 0.
  - `Halted=0`, `Stalled=0`.
- Reset mid-STALL or mid-HALT returns to RUN at `PC=0` on that edge.
- `Ready` latency: a change is visible in `RdySync` two edges after it is sampled, and the STALL exit follows on the next edge, so 3 edges worst case.
- A `Ready` pulse shorter than a clock period may be missed; this is acceptable.
- JMP/BZ have zero delay slots.

## Structure
- `picomips_pkg` holds:
  - `opcode_t` enum, 4-bit, values as above.
  - `cu_state_t` enum {RUN, STALL, HALT}.
  - `INSTR_W = 12`.
- Sub-module `sync2`: 2-flop synchroniser with synchronous active-low reset, reset value 0.
- Implementation is one `always_ff` for PC/state and one `always_comb` decoder, with a default of all-zeros.

## Test plan
- Reset then program LDI 5; ADDI 3; MULI 2; HALT: `WE=1` for 3 cycles with matching controls, PC 0→1→2→3, `Halted=1` from the cycle after HALT decodes, and PC stays 3.
- BZ taken vs not taken:
  - ACC=0 with `BZ 0x10` → PC=0x10 next cycle.
  - ACC=0x01 → PC+1.
  - With `PC_WIDTH=4`, `JMP 0xF3` → PC=3.
- WAITH with `Ready` low for 10 cycles, then high: `Stalled=1` and PC held; PC+1 exactly 3 edges after `Ready` rises; `WE=RegWE=0` throughout.
- WAITL while `RdySync` is already 0: no stall, PC advances next cycle.
- Wrap and illegal opcodes: PC=0xFF executing NOP → 0x00; opcode 0xD gives all enables 0 and PC+1.
- Reset asserted mid-STALL and mid-HALT: on the next edge PC=0, `Stalled=Halted=0`, and `WE=0` during reset even if `Instr` decodes LDI.
